// File: rtl/wddl_xor_pipe.sv
// Dual-rail (WDDL) XOR stage with a precharge spacer between results.
// Rejects words containing 00/11 rail pairs and keeps a sticky error flag and a saturating count.
module wddl_xor_pipe #(
  parameter int WIDTH      = 8,
  parameter int PRE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0_p_in,
  input  logic [WIDTH-1:0] d0_n_in,
  input  logic [WIDTH-1:0] d1_p_in,
  input  logic [WIDTH-1:0] d1_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d_p_out,
  output logic [WIDTH-1:0] d_n_out,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {IDLE, OUT, PRE} state_t;

  localparam logic [3:0] PRE_LAST = 4'(PRE_CYCLES - 1);

  state_t           r_state, w_state_next;
  logic [3:0]       r_pre_cnt, w_pre_cnt_next;
  logic [WIDTH-1:0] r_d_p, r_d_n, w_d_p_next, w_d_n_next;
  logic [WIDTH-1:0] w_xor_p, w_xor_n, w_pair_ok;
  logic             w_legal;
  logic             r_err, w_err_next;
  logic [7:0]       r_err_cnt, w_err_cnt_next;

  // Per-pair legality and dual-rail XOR; a legal pair pair yields exactly one active rail.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_pair_ok[gi] = (d0_p_in[gi] ^ d0_n_in[gi]) & (d1_p_in[gi] ^ d1_n_in[gi]);
      assign w_xor_p[gi]   = (d0_p_in[gi] & d1_n_in[gi]) | (d0_n_in[gi] & d1_p_in[gi]);
      assign w_xor_n[gi]   = (d0_p_in[gi] & d1_p_in[gi]) | (d0_n_in[gi] & d1_n_in[gi]);
    end
  endgenerate

  assign w_legal = &w_pair_ok;

  always_comb begin
    w_state_next   = r_state;
    w_pre_cnt_next = r_pre_cnt;
    w_d_p_next     = '0;
    w_d_n_next     = '0;
    w_err_next     = r_err;
    w_err_cnt_next = r_err_cnt;
    if (err_clr) begin
      w_err_next     = 1'b0;
      w_err_cnt_next = 8'd0;
    end
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_legal) begin
            w_state_next = OUT;
            w_d_p_next   = w_xor_p;
            w_d_n_next   = w_xor_n;
          end else begin
            // A rejection wins over a simultaneous clear: the count restarts at one.
            w_state_next   = PRE;
            w_pre_cnt_next = 4'd0;
            w_err_next     = 1'b1;
            if (err_clr)
              w_err_cnt_next = 8'd1;
            else if (r_err_cnt != 8'hFF)
              w_err_cnt_next = r_err_cnt + 8'd1;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          w_state_next   = PRE;
          w_pre_cnt_next = 4'd0;
        end else begin
          w_d_p_next = r_d_p;
          w_d_n_next = r_d_n;
        end
      end
      PRE: begin
        if (r_pre_cnt == PRE_LAST) begin
          w_state_next   = IDLE;
          w_pre_cnt_next = 4'd0;
        end else begin
          w_pre_cnt_next = r_pre_cnt + 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pre_cnt <= 4'd0;
      r_d_p     <= '0;
      r_d_n     <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_pre_cnt <= w_pre_cnt_next;
      r_d_p     <= w_d_p_next;
      r_d_n     <= w_d_n_next;
      r_err     <= w_err_next;
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign d_p_out   = r_d_p;
  assign d_n_out   = r_d_n;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_wddl_xor_pipe.sv
// Randomized self-checking bench for wddl_xor_pipe; two instances cover PRE_CYCLES=1 and 3.
module tb_wddl_xor_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d0_p = '0, d0_n = '0, d1_p = '0, d1_n = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
  logic       sel = 1'b0;

  logic       a_in_ready, a_out_valid, a_err, b_in_ready, b_out_valid, b_err;
  logic [7:0] a_dp, a_dn, a_cnt, b_dp, b_dn, b_cnt;
  logic       in_ready, out_valid, err;
  logic [7:0] d_p_out, d_n_out, err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  wddl_xor_pipe #(.WIDTH(8), .PRE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d0_p_in(d0_p), .d0_n_in(d0_n), .d1_p_in(d1_p), .d1_n_in(d1_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .d_p_out(a_dp), .d_n_out(a_dn),
    .out_valid(a_out_valid), .out_ready(out_ready), .err_clr(err_clr), .err(a_err), .err_cnt(a_cnt)
  );

  wddl_xor_pipe #(.WIDTH(8), .PRE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d0_p_in(d0_p), .d0_n_in(d0_n), .d1_p_in(d1_p), .d1_n_in(d1_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .d_p_out(b_dp), .d_n_out(b_dn),
    .out_valid(b_out_valid), .out_ready(out_ready), .err_clr(err_clr), .err(b_err), .err_cnt(b_cnt)
  );

  assign in_ready  = sel ? b_in_ready  : a_in_ready;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign d_p_out   = sel ? b_dp        : a_dp;
  assign d_n_out   = sel ? b_dn        : a_dn;
  assign err       = sel ? b_err       : a_err;
  assign err_cnt   = sel ? b_cnt       : a_cnt;

  function automatic int pre_len();
    return sel ? 3 : 1;
  endfunction

  task automatic check_reset_vals(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d_p_out !== 8'h00 || d_n_out !== 8'h00 ||
        err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b p=%h n=%h err=%b cnt=%0d, want rdy=1 vld=0 p=00 n=00 err=0 cnt=0",
               name, in_ready, out_valid, d_p_out, d_n_out, err, err_cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #1 check_reset_vals("reset_async");
    exp_err = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset sel=%0d", sel);
  endtask

  // One complete transaction: accept, optional stall in OUT, precharge gap, return to IDLE.
  task automatic do_txn(input logic [7:0] p0, n0, p1, n1, input int stall, input logic clr);
    logic       legal;
    logic [7:0] exp_p, exp_n;
    int         k;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: in_ready=%b after %0d cycles, want 1", in_ready, k);
    end
    d0_p = p0; d0_n = n0; d1_p = p1; d1_n = n1;
    in_valid = 1'b1; err_clr = clr; out_ready = $urandom_range(0, 1);
    legal = ((p0 ^ n0) == 8'hFF) && ((p1 ^ n1) == 8'hFF);
    exp_p = p0 ^ p1;
    exp_n = ~exp_p;
    if (!legal) begin
      exp_err = 1'b1;
      exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
    end else if (clr) begin
      exp_err = 1'b0;
      exp_cnt = 0;
    end
    @(negedge clk);
    err_clr = 1'b0;
    // Garbage with in_valid high outside IDLE must be ignored.
    d0_p = 8'($urandom); d0_n = 8'($urandom); d1_p = 8'($urandom); d1_n = 8'($urandom);
    if (legal) begin
      for (int s = 0; s <= stall; s++) begin
        out_ready = (s == stall);
        checks++;
        if (out_valid !== 1'b1 || d_p_out !== exp_p || d_n_out !== exp_n || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL out_word: cyc=%0d vld=%b p=%h n=%h rdy=%b, want vld=1 p=%h n=%h rdy=0",
                   s, out_valid, d_p_out, d_n_out, in_ready, exp_p, exp_n);
        end
        @(negedge clk);
      end
    end else begin
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b1 || err_cnt !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL reject: vld=%b err=%b cnt=%0d, want vld=0 err=1 cnt=%0d",
                 out_valid, err, err_cnt, exp_cnt);
      end
    end
    for (int c = 0; c < pre_len(); c++) begin
      checks++;
      if (out_valid !== 1'b0 || d_p_out !== 8'h00 || d_n_out !== 8'h00 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL pre_gap: cyc=%0d vld=%b p=%h n=%h rdy=%b, want vld=0 p=00 n=00 rdy=0",
                 c, out_valid, d_p_out, d_n_out, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || d_p_out !== 8'h00 || d_n_out !== 8'h00 ||
        err !== exp_err || err_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL idle_return: rdy=%b vld=%b p=%h n=%h err=%b cnt=%0d, want rdy=1 vld=0 p=00 n=00 err=%b cnt=%0d",
               in_ready, out_valid, d_p_out, d_n_out, err, err_cnt, exp_err, exp_cnt);
    end
    $display("txn sel=%0d p0=%h n0=%h p1=%h n1=%h legal=%0d stall=%0d clr=%0d res=%h cnt=%0d",
             sel, p0, n0, p1, n1, legal, stall, clr, exp_p, exp_cnt);
  endtask

  task automatic rand_txn(input int max_stall);
    logic [7:0] a, b, p0, n0, p1, n1;
    int bitpos;
    a = 8'($urandom); b = 8'($urandom);
    p0 = a; n0 = ~a; p1 = b; n1 = ~b;
    if ($urandom_range(0, 3) == 0) begin
      bitpos = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        p0[bitpos] = 1'b1; n0[bitpos] = 1'b1;
      end else begin
        p1[bitpos] = 1'b0; n1[bitpos] = 1'b0;
      end
    end
    do_txn(p0, n0, p1, n1, $urandom_range(0, max_stall), 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_vals("reset_release");
  endtask

  task automatic test_scenario_a5();
    do_txn(8'hA5, 8'h5A, 8'h0F, 8'hF0, 0, 1'b0);
  endtask

  task automatic test_illegal_bit3();
    do_txn(8'hAD, 8'h5A, 8'h0F, 8'hF0, 0, 1'b0);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL illegal_bit3: err=%b cnt=%0d, want err=1 cnt=1", err, err_cnt);
    end
  endtask

  task automatic test_stall();
    do_txn(8'h3C, 8'hC3, 8'h96, 8'h69, 5, 1'b0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) rand_txn(3);
  endtask

  task automatic test_err_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    exp_cnt = 0;
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_clr: err=%b cnt=%0d, want err=0 cnt=0", err, err_cnt);
    end
    do_txn(8'h00, 8'hFF, 8'h00, 8'hFF, 0, 1'b0);
    do_txn(8'h01, 8'hFF, 8'h00, 8'hFF, 0, 1'b0);
    do_txn(8'h00, 8'hFE, 8'h00, 8'hFF, 0, 1'b1);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL clr_with_reject: err=%b cnt=%0d, want err=1 cnt=1", err, err_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) do_txn(8'hFF, 8'hFF, 8'h12, 8'hED, 0, 1'b0);
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL saturate: cnt=%0d, want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid(input bit in_pre);
    d0_p = 8'h55; d0_n = 8'hAA; d1_p = 8'h0F; d1_n = 8'hF0;
    in_valid = 1'b1; out_ready = in_pre;
    @(negedge clk);
    in_valid = 1'b0;
    if (in_pre) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals(in_pre ? "reset_mid_pre" : "reset_mid_out");
    exp_err = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_reset_vals("post_abort");
    end
    // First edge after release with in_valid=1 must accept.
    do_txn(8'hF0, 8'h0F, 8'h33, 8'hCC, 0, 1'b0);
  endtask

  initial begin
    sel = 1'b0;
    test_reset();
    test_scenario_a5();
    test_illegal_bit3();
    test_stall();
    test_random(40);
    test_err_clr();
    test_saturate();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    sel = 1'b1;
    test_reset();
    test_scenario_a5();
    test_stall();
    test_random(25);
    test_reset_mid(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
